led_run_monitor: RTL and testbench
==================================

Name: led_run_monitor

Overview:
- Receive-side checker for the 8-bit one-hot LED chaser bus. It samples the pattern on a strobe and decodes the lit position, travel direction and lock status.
- Flags illegal patterns and illegal jumps, and keeps a saturating error count.
- Sits on the LED bus, alongside the chaser, as a self-check and debug block.

Parameters:
- LOCK_CNT, 4: consecutive same-direction valid steps required to enter LOCKED (legal range 1..15).
- ERR_W, 8: width of the error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- sample_en  input  1  qualifies led_i. Evaluated only on cycles where it is high.
- led_i  input  8  LED pattern under observation.
- clr_err  input  1  synchronous clear of err_cnt_o.
- pos_o  output  3  index of the lit bit from the last one-hot sample.
- dir_o  output  1  travel direction: 0 = up (bit n to n+1), 1 = down.
- locked_o  output  1  high while the FSM is in LOCKED.
- err_o  output  1  one-cycle pulse on a detected error.
- dir_chg_o  output  1  one-cycle pulse on a legal direction reversal while LOCKED.
- err_cnt_o  output  ERR_W  saturating error count.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All outputs go to 0 while rst_n is low: pos_o=0, dir_o=0, locked_o=0, err_o=0, dir_chg_o=0, err_cnt_o=0. FSM goes to IDLE, run counter to 0, reference position to 0.
- Reset mid-operation: all state is discarded and the monitor re-acquires from IDLE.
- Latency: all outputs are registered and reflect a sample one clk after the sample_en cycle. With sample_en low, state holds and the pulses deassert.
- Classification of each sample:
  - onehot: exactly one bit of led_i is set.
  - blank: led_i = 0.
  - multi: more than one bit set.
- Delta: d = new_pos - ref_pos, modulo 8 (3-bit subtraction).
  - d=1: step up.
  - d=7: step down.
  - d=0: hold.
  - any other value: jump.
- Wrap-around: 8'h80 to 8'h01 is a step up; 8'h01 to 8'h80 is a step down.
- On every onehot sample: ref_pos and pos_o take the new index, in all states.
- IDLE:
  - onehot: go to ACQUIRE, run=0.
  - blank or multi: stay in IDLE. No error is raised.
- ACQUIRE:
  - step with run=0: dir_o takes the step direction, run=1.
  - step matching dir_o: run increments.
  - step opposite to dir_o: dir_o flips, run=1.
  - hold: no change.
  - jump: stay in ACQUIRE, run=0.
  - blank or multi: go to IDLE, run=0.
  - No errors are raised in ACQUIRE.
  - Lock: when run reaches LOCK_CNT, go to LOCKED and set locked_o=1. With LOCK_CNT=1, the first step locks.
- LOCKED:
  - step matching dir_o: legal, no change.
  - hold: legal, no change.
  - step opposite to dir_o: legal; dir_o flips and dir_chg_o pulses.
  - jump: error; err_o pulses, go to ACQUIRE with run=0.
  - blank or multi: error; err_o pulses, go to IDLE.
  - On any error exit, locked_o drops in the same update.
- Error counter:
  - Increments by 1 on each err_o pulse and saturates at 2^ERR_W-1.
  - clr_err sets the counter to 0.
  - clr_err in the same cycle as an error gives a result of 1 (clear first, then count).
- pos_o holds its last value across blank and multi samples.

Test Plan:
- Reset, then samples 01,02,04,08,10 on consecutive cycles -> locked_o=1 one clk after the 10 sample; dir_o=0, pos_o=4, err_cnt_o=0.
- Up-counting wrap: locked, then 40,80,01,02 -> no err_o, pos_o sequence 6,7,0,1, locked_o stays 1.
- Reversal: locked going up at 08, then sample 04 -> dir_chg_o pulses one cycle, dir_o=1, locked_o=1, err_o=0; then 02,01,80 -> pos_o=7, no error.
- Jump: locked at 02, then sample 20 -> err_o pulse, err_cnt_o=1, locked_o=0, pos_o=5. Then 40,80,01,02 -> relocks.
- Illegal pattern: locked, then sample 0x03 -> err_o, FSM in IDLE, pos_o unchanged. Then sample 00 in IDLE -> no error. Later clr_err with a simultaneous error -> err_cnt_o=1.
- Saturation and gating: force 300 errors with ERR_W=8 -> err_cnt_o=255. Toggle led_i with sample_en=0 -> outputs unchanged. Assert rst_n low mid-lock -> all outputs read 0 immediately.

Source files
------------

// File: rtl/led_run_monitor.sv
// led_run_monitor
//   Receive-side checker for an 8-bit one-hot LED chaser bus. On each
//   sample_en cycle it classifies led_i, tracks the lit position and travel
//   direction, locks onto a steady run and flags illegal patterns / jumps.
//
//   Ports:
//     clk, rst_n   clock (rising edge), async active-low reset
//     sample_en    qualifies led_i
//     led_i[7:0]   observed LED pattern
//     clr_err      synchronous clear of err_cnt_o (applied before counting)
//     pos_o[2:0]   index of the lit bit from the last one-hot sample
//     dir_o        0 = up (n -> n+1), 1 = down
//     locked_o     high while in LOCKED
//     err_o        one-cycle pulse on an error (only raised in LOCKED)
//     dir_chg_o    one-cycle pulse on a legal reversal while LOCKED
//     err_cnt_o    saturating error count
module led_run_monitor #(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic [7:0]       led_i,
  input  logic             clr_err,
  output logic [2:0]       pos_o,
  output logic             dir_o,
  output logic             locked_o,
  output logic             err_o,
  output logic             dir_chg_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK} state_e;

  localparam logic [3:0] LOCK_V = 4'(LOCK_CNT);

  state_e           state_q, state_d;
  logic [3:0]       run_q, run_d;
  // The reference position and pos_o always take the same value (every
  // one-hot sample updates both), so a single register serves as both.
  logic [2:0]       pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             dir_chg_q, dir_chg_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // Sample classification
  logic [3:0] ones;
  logic [2:0] idx;
  logic [2:0] delta;
  logic       onehot, step, step_dn, hold, jump, opposite;

  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < 8; i++) begin
      if (led_i[i]) begin
        ones = ones + 4'd1;
        idx  = 3'(i);
      end
    end
    onehot   = (ones == 4'd1);
    // Modulo-8 difference gives the wrap-around (7 -> 0 is +1) for free.
    delta    = idx - pos_q;
    step_dn  = (delta == 3'd7);
    step     = (delta == 3'd1) || step_dn;
    hold     = (delta == 3'd0);
    jump     = !(step || hold);
    opposite = step && (step_dn != dir_q);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      run_q     <= '0;
      pos_q     <= '0;
      dir_q     <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      dir_chg_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      dir_chg_q <= dir_chg_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next-state and run counter
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (sample_en) begin
      case (state_q)
        S_IDLE: begin
          if (onehot) begin
            state_d = S_ACQ;
            run_d   = '0;
          end
        end
        S_ACQ: begin
          if (!onehot) begin
            state_d = S_IDLE;
            run_d   = '0;
          end else if (jump) begin
            run_d = '0;
          end else if (step) begin
            // A reversal (or the first step) starts a fresh run of 1.
            run_d = opposite ? 4'd1 : run_q + 4'd1;
            if (run_d == LOCK_V) state_d = S_LOCK;
          end
        end
        S_LOCK: begin
          if (!onehot) begin
            state_d = S_IDLE;
            run_d   = '0;
          end else if (jump) begin
            state_d = S_ACQ;
            run_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          run_d   = '0;
        end
      endcase
    end
  end

  // Registered outputs
  always_comb begin
    pos_d     = (sample_en && onehot) ? idx : pos_q;
    dir_d     = dir_q;
    // In ACQUIRE and LOCKED every step leaves dir equal to the step direction,
    // whether it matches, reverses, or is the first step of a run.
    if (sample_en && onehot && step && state_q != S_IDLE) dir_d = step_dn;
    locked_d  = (state_d == S_LOCK);
    err_d     = sample_en && (state_q == S_LOCK) && (!onehot || jump);
    dir_chg_d = sample_en && (state_q == S_LOCK) && onehot && opposite;
    err_cnt_d = clr_err ? '0 : err_cnt_q;
    if (err_d && err_cnt_d != '1) err_cnt_d = err_cnt_d + 1'b1;
  end

  assign pos_o     = pos_q;
  assign dir_o     = dir_q;
  assign locked_o  = locked_q;
  assign err_o     = err_q;
  assign dir_chg_o = dir_chg_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_led_run_monitor.sv
module tb_led_run_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_en = 1'b0;
  logic [7:0] led_i = 8'h00;
  logic       clr_err = 1'b0;
  logic [2:0] pos_o;
  logic       dir_o, locked_o, err_o, dir_chg_o;
  logic [7:0] err_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  led_run_monitor #(.LOCK_CNT(4), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .led_i(led_i),
    .clr_err(clr_err), .pos_o(pos_o), .dir_o(dir_o), .locked_o(locked_o),
    .err_o(err_o), .dir_chg_o(dir_chg_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  // Packed view: {pos[2:0], dir, locked, err, dir_chg}
  wire [6:0] st = {pos_o, dir_o, locked_o, err_o, dir_chg_o};

  // One sample_en cycle; outputs are read 1 time unit after the edge.
  task automatic smp(input logic [7:0] v);
    sample_en = 1'b1;
    led_i     = v;
    @(posedge clk); #1;
    sample_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    if ({st, err_cnt_o} !== 15'd0) begin
      $display("FAIL reset got st=%b cnt=%0d exp 0", st, err_cnt_o); n_bad++;
    end
    n_cmp++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    smp(8'h01); smp(8'h02); smp(8'h04); smp(8'h08);
    if (locked_o !== 1'b0) begin
      $display("FAIL lock_early got %b exp 0", locked_o); n_bad++;
    end
    n_cmp++;
    smp(8'h10);
    if ({st, err_cnt_o} !== {3'd4, 4'b0100, 8'd0}) begin
      $display("FAIL lock got st=%b cnt=%0d exp st=1000100 cnt=0", st, err_cnt_o); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_wrap();
    logic [7:0] pat [5];
    logic [2:0] exp_pos [5];
    pat = '{8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    exp_pos = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    for (int i = 0; i < 5; i++) begin
      smp(pat[i]);
      if (st !== {exp_pos[i], 4'b0100}) begin
        $display("FAIL wrap[%0d] got %b exp %b", i, st, {exp_pos[i], 4'b0100}); n_bad++;
      end
      n_cmp++;
    end
    smp(8'h02);  // hold is legal
    if (st !== {3'd1, 4'b0100}) begin
      $display("FAIL hold got %b exp %b", st, {3'd1, 4'b0100}); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_reversal();
    smp(8'h04); smp(8'h08);
    smp(8'h04);
    if (st !== {3'd2, 4'b1101}) begin
      $display("FAIL reversal got %b exp %b", st, {3'd2, 4'b1101}); n_bad++;
    end
    n_cmp++;
    smp(8'h02);
    if (st !== {3'd1, 4'b1100}) begin
      $display("FAIL rev_pulse_end got %b exp %b", st, {3'd1, 4'b1100}); n_bad++;
    end
    n_cmp++;
    smp(8'h01); smp(8'h80);
    if ({st, err_cnt_o} !== {3'd7, 4'b1100, 8'd0}) begin
      $display("FAIL rev_wrap got st=%b cnt=%0d exp st=1111100 cnt=0", st, err_cnt_o); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_jump();
    do_reset();
    smp(8'h20); smp(8'h40); smp(8'h80); smp(8'h01); smp(8'h02);
    if (st !== {3'd1, 4'b0100}) begin
      $display("FAIL jump_pre got %b exp %b", st, {3'd1, 4'b0100}); n_bad++;
    end
    n_cmp++;
    smp(8'h20);
    if ({st, err_cnt_o} !== {3'd5, 4'b0010, 8'd1}) begin
      $display("FAIL jump got st=%b cnt=%0d exp st=1010010 cnt=1", st, err_cnt_o); n_bad++;
    end
    n_cmp++;
    smp(8'h40); smp(8'h80); smp(8'h01);
    if (locked_o !== 1'b0) begin
      $display("FAIL relock_early got %b exp 0", locked_o); n_bad++;
    end
    n_cmp++;
    smp(8'h02);
    if ({st, err_cnt_o} !== {3'd1, 4'b0100, 8'd1}) begin
      $display("FAIL relock got st=%b cnt=%0d exp st=0010100 cnt=1", st, err_cnt_o); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_illegal();
    smp(8'h03);
    if ({st, err_cnt_o} !== {3'd1, 4'b0010, 8'd2}) begin
      $display("FAIL multi got st=%b cnt=%0d exp st=0010010 cnt=2", st, err_cnt_o); n_bad++;
    end
    n_cmp++;
    smp(8'h00);
    if ({st, err_cnt_o} !== {3'd1, 4'b0000, 8'd2}) begin
      $display("FAIL blank_idle got st=%b cnt=%0d exp st=0010000 cnt=2", st, err_cnt_o); n_bad++;
    end
    n_cmp++;
    smp(8'h04); smp(8'h08); smp(8'h10); smp(8'h20); smp(8'h40);
    if (st !== {3'd6, 4'b0100}) begin
      $display("FAIL relock2 got %b exp %b", st, {3'd6, 4'b0100}); n_bad++;
    end
    n_cmp++;
    clr_err = 1'b1;
    smp(8'h03);
    clr_err = 1'b0;
    if ({st, err_cnt_o} !== {3'd6, 4'b0010, 8'd1}) begin
      $display("FAIL clr_collide got st=%b cnt=%0d exp st=1100010 cnt=1", st, err_cnt_o); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_saturation();
    logic [2:0] p;
    do_reset();
    smp(8'h01); smp(8'h02); smp(8'h04); smp(8'h08); smp(8'h10);
    p = 3'd4;
    for (int i = 0; i < 300; i++) begin
      p = p + 3'd4;
      smp(8'd1 << p);
      if (i == 9) begin
        if ({err_o, err_cnt_o} !== {1'b1, 8'd10}) begin
          $display("FAIL sat_mid got err=%b cnt=%0d exp err=1 cnt=10", err_o, err_cnt_o); n_bad++;
        end
        n_cmp++;
      end
      for (int k = 0; k < 4; k++) begin
        p = p + 3'd1;
        smp(8'd1 << p);
      end
    end
    if ({st, err_cnt_o} !== {p, 4'b0100, 8'd255}) begin
      $display("FAIL saturate got st=%b cnt=%0d exp st=%b cnt=255", st, err_cnt_o, {p, 4'b0100}); n_bad++;
    end
    n_cmp++;
    test_gating(p);
  endtask

  task automatic test_gating(input logic [2:0] p);
    logic [2:0] q;
    q = p - 3'd1;
    smp(8'd1 << q);
    if (st !== {q, 4'b1101}) begin
      $display("FAIL gate_rev got %b exp %b", st, {q, 4'b1101}); n_bad++;
    end
    n_cmp++;
    for (int i = 0; i < 5; i++) begin
      led_i = 8'(1 << i) ^ 8'h5A;
      @(posedge clk); #1;
      if ({st, err_cnt_o} !== {q, 4'b1100, 8'd255}) begin
        $display("FAIL gate[%0d] got st=%b cnt=%0d exp st=%b cnt=255", i, st, err_cnt_o, {q, 4'b1100}); n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_midreset();
    #2;
    rst_n = 1'b0;
    #1;
    if ({st, err_cnt_o} !== 15'd0) begin
      $display("FAIL midreset got st=%b cnt=%0d exp 0", st, err_cnt_o); n_bad++;
    end
    n_cmp++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    smp(8'h02);
    if (st !== {3'd1, 4'b0000}) begin
      $display("FAIL reacq got %b exp %b", st, {3'd1, 4'b0000}); n_bad++;
    end
    n_cmp++;
    smp(8'h04); smp(8'h08); smp(8'h10); smp(8'h20);
    if ({st, err_cnt_o} !== {3'd5, 4'b0100, 8'd0}) begin
      $display("FAIL reacq_lock got st=%b cnt=%0d exp st=1010100 cnt=0", st, err_cnt_o); n_bad++;
    end
    n_cmp++;
  endtask

  initial begin
    #3;
    test_reset();
    test_lock();
    test_wrap();
    test_reversal();
    test_jump();
    test_illegal();
    test_saturation();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
